// File: rtl/axi4s_pattern_gen.sv
// AXI4-Stream video pattern source with runtime geometry, four patterns and a frame counter.
// Define AXI4S_PATTERN_GEN_GAP_EN to build the line/frame blanking (HGAP/VGAP) logic.
module axi4s_pattern_gen #(
  parameter int TDATA_WIDTH = 32,
  parameter int X_WIDTH     = 12,
  parameter int Y_WIDTH     = 12,
  parameter int GAP_WIDTH   = 8
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   enable,
  input  logic [X_WIDTH-1:0]     param_width,
  input  logic [Y_WIDTH-1:0]     param_height,
  input  logic [1:0]             param_mode,
  input  logic [TDATA_WIDTH-1:0] param_color,
  input  logic [GAP_WIDTH-1:0]   param_hgap,
  input  logic [GAP_WIDTH-1:0]   param_vgap,
  output logic                   m_axi4s_tuser,
  output logic                   m_axi4s_tlast,
  output logic [TDATA_WIDTH-1:0] m_axi4s_tdata,
  output logic                   m_axi4s_tvalid,
  input  logic                   m_axi4s_tready,
  output logic [15:0]            frame_count,
  output logic                   busy
);

  localparam int HW = TDATA_WIDTH / 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HGAP   = 2'd2,
    ST_VGAP   = 2'd3
  } state_t;

  function automatic logic [X_WIDTH-1:0] fix_width(input logic [X_WIDTH-1:0] w);
    return (w == {X_WIDTH{1'b0}}) ? X_WIDTH'(1'b1) : w;
  endfunction

  function automatic logic [Y_WIDTH-1:0] fix_height(input logic [Y_WIDTH-1:0] h);
    return (h == {Y_WIDTH{1'b0}}) ? Y_WIDTH'(1'b1) : h;
  endfunction

  function automatic logic [X_WIDTH-1:0] bar_length(input logic [X_WIDTH-1:0] w);
    logic [X_WIDTH-1:0] l;
    l = w >> 2'd3;
    return (l == {X_WIDTH{1'b0}}) ? X_WIDTH'(1'b1) : l;
  endfunction

  function automatic logic [TDATA_WIDTH-1:0] pixel(
    input logic [1:0]             mode,
    input logic [TDATA_WIDTH-1:0] color,
    input logic [X_WIDTH-1:0]     x,
    input logic [Y_WIDTH-1:0]     y,
    input logic [15:0]            fc,
    input logic [2:0]             bar
  );
    logic [TDATA_WIDTH-1:0] xe;
    logic [TDATA_WIDTH-1:0] ye;
    logic [23:0]            bars;
    xe   = TDATA_WIDTH'(x);
    ye   = TDATA_WIDTH'(y);
    bars = {{8{~bar[2]}}, {8{~bar[1]}}, {8{~bar[0]}}};
    case (mode)
      2'd0:    pixel = {ye[HW-1:0], xe[HW-1:0]};
      2'd1:    pixel = TDATA_WIDTH'(bars);
      2'd2:    pixel = color;
      2'd3:    pixel = xe + ye + TDATA_WIDTH'(fc);
      default: pixel = {TDATA_WIDTH{1'b0}};
    endcase
  endfunction

  state_t                 state_r;
  logic [X_WIDTH-1:0]     x_r, w_r, bar_len_r, bar_cnt_r;
  logic [Y_WIDTH-1:0]     y_r, h_r;
  logic [1:0]             mode_r;
  logic [TDATA_WIDTH-1:0] color_r, tdata_r;
  logic [2:0]             bar_r;
  logic [15:0]            frame_count_r;
  logic                   tvalid_r, tuser_r, tlast_r, busy_r;

  logic                   accept_s, eol_s, eof_s, frame_done_s, frame_end_s, restart_s;
  logic [15:0]            fc_next_s;
  logic [X_WIDTH-1:0]     x_inc_s, w_start_s, bar_cnt_next_s;
  logic [Y_WIDTH-1:0]     h_start_s;
  logic [2:0]             bar_next_s;

`ifdef AXI4S_PATTERN_GEN_GAP_EN
  logic [GAP_WIDTH-1:0]   hgap_r, vgap_r, gap_cnt_r;
`else
  logic                   unused_gap_s;
  assign unused_gap_s = ^{param_hgap, param_vgap};
`endif

  // Handshake, line/frame boundary detection and next-pixel bookkeeping
  always_comb begin
    accept_s       = tvalid_r & m_axi4s_tready;
    eol_s          = (x_r == w_r - X_WIDTH'(1'b1));
    eof_s          = eol_s & (y_r == h_r - Y_WIDTH'(1'b1));
    frame_done_s   = accept_s & eof_s;
    fc_next_s      = frame_done_s ? frame_count_r + 16'd1 : frame_count_r;
    x_inc_s        = x_r + X_WIDTH'(1'b1);
    w_start_s      = fix_width(param_width);
    h_start_s      = fix_height(param_height);
    if (bar_cnt_r == bar_len_r - X_WIDTH'(1'b1)) begin
      bar_cnt_next_s = {X_WIDTH{1'b0}};
      bar_next_s     = (bar_r == 3'd7) ? 3'd7 : bar_r + 3'd1;
    end else begin
      bar_cnt_next_s = bar_cnt_r + X_WIDTH'(1'b1);
      bar_next_s     = bar_r;
    end
`ifdef AXI4S_PATTERN_GEN_GAP_EN
    frame_end_s = (frame_done_s & (vgap_r == {GAP_WIDTH{1'b0}})) |
                  ((state_r == ST_VGAP) & (gap_cnt_r == GAP_WIDTH'(1'b1)));
`else
    frame_end_s = frame_done_s;
`endif
    restart_s = enable & ((state_r == ST_IDLE) | frame_end_s);
  end

  // Frame sequencer; outputs are loaded with the next beat whenever the position advances
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r       <= ST_IDLE;
      x_r           <= {X_WIDTH{1'b0}};
      y_r           <= {Y_WIDTH{1'b0}};
      w_r           <= X_WIDTH'(1'b1);
      h_r           <= Y_WIDTH'(1'b1);
      mode_r        <= 2'd0;
      color_r       <= {TDATA_WIDTH{1'b0}};
      bar_len_r     <= X_WIDTH'(1'b1);
      bar_cnt_r     <= {X_WIDTH{1'b0}};
      bar_r         <= 3'd0;
      frame_count_r <= 16'd0;
      tdata_r       <= {TDATA_WIDTH{1'b0}};
      tvalid_r      <= 1'b0;
      tuser_r       <= 1'b0;
      tlast_r       <= 1'b0;
      busy_r        <= 1'b0;
`ifdef AXI4S_PATTERN_GEN_GAP_EN
      hgap_r        <= {GAP_WIDTH{1'b0}};
      vgap_r        <= {GAP_WIDTH{1'b0}};
      gap_cnt_r     <= {GAP_WIDTH{1'b0}};
`endif
    end else begin
      frame_count_r <= fc_next_s;
      if (restart_s) begin
        state_r   <= ST_ACTIVE;
        busy_r    <= 1'b1;
        x_r       <= {X_WIDTH{1'b0}};
        y_r       <= {Y_WIDTH{1'b0}};
        w_r       <= w_start_s;
        h_r       <= h_start_s;
        mode_r    <= param_mode;
        color_r   <= param_color;
        bar_len_r <= bar_length(w_start_s);
        bar_cnt_r <= {X_WIDTH{1'b0}};
        bar_r     <= 3'd0;
`ifdef AXI4S_PATTERN_GEN_GAP_EN
        hgap_r    <= param_hgap;
        vgap_r    <= param_vgap;
`endif
        tvalid_r  <= 1'b1;
        tuser_r   <= 1'b1;
        tlast_r   <= (w_start_s == X_WIDTH'(1'b1));
        tdata_r   <= pixel(param_mode, param_color, {X_WIDTH{1'b0}}, {Y_WIDTH{1'b0}},
                           fc_next_s, 3'd0);
      end else begin
        case (state_r)
          ST_ACTIVE: begin
            if (accept_s) begin
              if (!eol_s) begin
                x_r       <= x_inc_s;
                bar_r     <= bar_next_s;
                bar_cnt_r <= bar_cnt_next_s;
                tuser_r   <= 1'b0;
                tlast_r   <= (x_inc_s == w_r - X_WIDTH'(1'b1));
                tdata_r   <= pixel(mode_r, color_r, x_inc_s, y_r, frame_count_r, bar_next_s);
              end else if (!eof_s) begin
                // Next line's first beat is staged now and simply held through any HGAP
                x_r       <= {X_WIDTH{1'b0}};
                y_r       <= y_r + Y_WIDTH'(1'b1);
                bar_r     <= 3'd0;
                bar_cnt_r <= {X_WIDTH{1'b0}};
                tuser_r   <= 1'b0;
                tlast_r   <= (w_r == X_WIDTH'(1'b1));
                tdata_r   <= pixel(mode_r, color_r, {X_WIDTH{1'b0}}, y_r + Y_WIDTH'(1'b1),
                                   frame_count_r, 3'd0);
`ifdef AXI4S_PATTERN_GEN_GAP_EN
                if (hgap_r != {GAP_WIDTH{1'b0}}) begin
                  state_r   <= ST_HGAP;
                  gap_cnt_r <= hgap_r;
                  tvalid_r  <= 1'b0;
                end else begin
                  state_r   <= ST_ACTIVE;
                end
`endif
              end else begin
                tvalid_r <= 1'b0;
                tuser_r  <= 1'b0;
                tlast_r  <= 1'b0;
`ifdef AXI4S_PATTERN_GEN_GAP_EN
                if (vgap_r != {GAP_WIDTH{1'b0}}) begin
                  state_r   <= ST_VGAP;
                  gap_cnt_r <= vgap_r;
                end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                end
`else
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
`endif
              end
            end
          end
`ifdef AXI4S_PATTERN_GEN_GAP_EN
          ST_HGAP: begin
            if (gap_cnt_r == GAP_WIDTH'(1'b1)) begin
              state_r  <= ST_ACTIVE;
              tvalid_r <= 1'b1;
            end else begin
              gap_cnt_r <= gap_cnt_r - GAP_WIDTH'(1'b1);
            end
          end
          ST_VGAP: begin
            if (gap_cnt_r == GAP_WIDTH'(1'b1)) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              gap_cnt_r <= gap_cnt_r - GAP_WIDTH'(1'b1);
            end
          end
`endif
          default: state_r <= state_r;
        endcase
      end
    end
  end

  assign m_axi4s_tuser  = tuser_r;
  assign m_axi4s_tlast  = tlast_r;
  assign m_axi4s_tdata  = tdata_r;
  assign m_axi4s_tvalid = tvalid_r;
  assign frame_count    = frame_count_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_axi4s_pattern_gen.sv
// Directed self-checking bench for axi4s_pattern_gen (gap scenario follows AXI4S_PATTERN_GEN_GAP_EN).
module tb_axi4s_pattern_gen;

  logic        aclk;
  logic        areset;
  logic        enable;
  logic [11:0] param_width;
  logic [11:0] param_height;
  logic [1:0]  param_mode;
  logic [31:0] param_color;
  logic [7:0]  param_hgap;
  logic [7:0]  param_vgap;
  logic        m_axi4s_tuser;
  logic        m_axi4s_tlast;
  logic [31:0] m_axi4s_tdata;
  logic        m_axi4s_tvalid;
  logic        m_axi4s_tready;
  logic [15:0] frame_count;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  axi4s_pattern_gen #(
    .TDATA_WIDTH(32), .X_WIDTH(12), .Y_WIDTH(12), .GAP_WIDTH(8)
  ) dut (
    .aclk(aclk), .areset(areset), .enable(enable),
    .param_width(param_width), .param_height(param_height), .param_mode(param_mode),
    .param_color(param_color), .param_hgap(param_hgap), .param_vgap(param_vgap),
    .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast),
    .m_axi4s_tdata(m_axi4s_tdata), .m_axi4s_tvalid(m_axi4s_tvalid),
    .m_axi4s_tready(m_axi4s_tready), .frame_count(frame_count), .busy(busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_reset();
    areset = 1'b1;
    step();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    n_checks++; if (m_axi4s_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b want 0", m_axi4s_tvalid); end
    n_checks++; if (m_axi4s_tuser !== 1'b0) begin n_fail++; $display("FAIL reset_tuser got %b want 0", m_axi4s_tuser); end
    n_checks++; if (m_axi4s_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %b want 0", m_axi4s_tlast); end
    n_checks++; if (m_axi4s_tdata !== 32'h0) begin n_fail++; $display("FAIL reset_tdata got %h want 0", m_axi4s_tdata); end
    n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_fc got %0d want 0", frame_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    areset = 1'b0;
    step();
  endtask

  task automatic test_mode0();
    logic [31:0] exp;
    param_width = 12'd4; param_height = 12'd3; param_mode = 2'd0;
    enable = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      if (i == 1) enable = 1'b0;
      exp = {16'(i / 4), 16'(i % 4)};
      n_checks++; if (m_axi4s_tvalid !== 1'b1) begin n_fail++; $display("FAIL m0_tvalid beat %0d got %b want 1", i, m_axi4s_tvalid); end
      n_checks++; if (m_axi4s_tdata !== exp) begin n_fail++; $display("FAIL m0_tdata beat %0d got %h want %h", i, m_axi4s_tdata, exp); end
      n_checks++; if (m_axi4s_tuser !== (i == 0)) begin n_fail++; $display("FAIL m0_tuser beat %0d got %b", i, m_axi4s_tuser); end
      n_checks++; if (m_axi4s_tlast !== (i % 4 == 3)) begin n_fail++; $display("FAIL m0_tlast beat %0d got %b", i, m_axi4s_tlast); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL m0_busy beat %0d got %b want 1", i, busy); end
      step();
    end
    n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL m0_fc got %0d want 1", frame_count); end
    n_checks++; if (m_axi4s_tvalid !== 1'b0) begin n_fail++; $display("FAIL m0_end_tvalid got %b want 0", m_axi4s_tvalid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL m0_end_busy got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int k;
    int f, p, x, y;
    logic r;
    logic [31:0] exp;
    pulse_reset();
    param_width = 12'd8; param_height = 12'd2; param_mode = 2'd3;
    m_axi4s_tready = 1'b0;
    enable = 1'b1;
    step();
    k = 0;
    for (int cyc = 0; cyc < 400 && k < 32; cyc++) begin
      if (k == 17) enable = 1'b0;
      r = 1'($urandom_range(0, 1));
      m_axi4s_tready = r;
      f = k / 16; p = k % 16; x = p % 8; y = p / 8;
      exp = 32'(x + y + f);
      n_checks++; if (m_axi4s_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_tvalid beat %0d got %b want 1", k, m_axi4s_tvalid); end
      n_checks++; if (m_axi4s_tdata !== exp) begin n_fail++; $display("FAIL bp_tdata beat %0d got %h want %h", k, m_axi4s_tdata, exp); end
      n_checks++; if (m_axi4s_tuser !== (p == 0)) begin n_fail++; $display("FAIL bp_tuser beat %0d got %b", k, m_axi4s_tuser); end
      n_checks++; if (m_axi4s_tlast !== (x == 7)) begin n_fail++; $display("FAIL bp_tlast beat %0d got %b", k, m_axi4s_tlast); end
      if (r) k++;
      step();
    end
    m_axi4s_tready = 1'b1;
    n_checks++; if (k != 32) begin n_fail++; $display("FAIL bp_timeout got %0d beats want 32", k); end
    n_checks++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL bp_fc got %0d want 2", frame_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy got %b want 0", busy); end
  endtask

  task automatic test_gaps();
    int n;
    logic [12:0] pat;
`ifdef AXI4S_PATTERN_GEN_GAP_EN
    pat = 13'b1000001100011;
    n   = 13;
`else
    pat = 13'b0000000011111;
    n   = 5;
`endif
    pulse_reset();
    param_width = 12'd2; param_height = 12'd2; param_mode = 2'd0;
    param_hgap = 8'd3; param_vgap = 8'd5;
    enable = 1'b1;
    step();
    for (int j = 0; j < n; j++) begin
      n_checks++; if (m_axi4s_tvalid !== pat[j]) begin n_fail++; $display("FAIL gap_tvalid cycle %0d got %b want %b", j, m_axi4s_tvalid, pat[j]); end
      step();
    end
    // The cycle just checked last is the first beat of the second frame
    n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL gap_fc got %0d want 1", frame_count); end
    enable = 1'b0;
    for (int j = 0; j < 40 && busy === 1'b1; j++) step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gap_idle_timeout busy %b want 0", busy); end
    param_hgap = 8'd0; param_vgap = 8'd0;
  endtask

  task automatic test_restart_tuser();
    // Checks the tuser/tdata of the first beat after gaps, in whichever build
    pulse_reset();
    param_width = 12'd2; param_height = 12'd2; param_mode = 2'd0;
    param_hgap = 8'd2; param_vgap = 8'd2;
    enable = 1'b1;
    step();
    for (int j = 0; j < 4; j++) begin
      for (int w = 0; w < 10 && m_axi4s_tvalid !== 1'b1; w++) step();
      n_checks++; if (m_axi4s_tdata !== {16'(j / 2), 16'(j % 2)}) begin n_fail++; $display("FAIL gr_tdata beat %0d got %h", j, m_axi4s_tdata); end
      step();
    end
    for (int w = 0; w < 10 && m_axi4s_tvalid !== 1'b1; w++) step();
    n_checks++; if (m_axi4s_tuser !== 1'b1) begin n_fail++; $display("FAIL gr_tuser got %b want 1", m_axi4s_tuser); end
    enable = 1'b0;
    for (int j = 0; j < 40 && busy === 1'b1; j++) step();
    param_hgap = 8'd0; param_vgap = 8'd0;
  endtask

  task automatic test_colour_bars();
    logic [23:0] bars [0:7];
    logic [31:0] exp;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'hFF00FF, 24'hFF0000,
             24'h00FFFF, 24'h00FF00, 24'h0000FF, 24'h000000};
    param_width = 12'd16; param_height = 12'd1; param_mode = 2'd1;
    enable = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      if (i == 1) enable = 1'b0;
      exp = {8'h00, bars[i / 2]};
      n_checks++; if (m_axi4s_tdata !== exp) begin n_fail++; $display("FAIL cb_tdata beat %0d got %h want %h", i, m_axi4s_tdata, exp); end
      n_checks++; if (m_axi4s_tlast !== (i == 15)) begin n_fail++; $display("FAIL cb_tlast beat %0d got %b", i, m_axi4s_tlast); end
      step();
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cb_busy got %b want 0", busy); end
  endtask

  task automatic test_stop_reset();
    int cnt;
    param_width = 12'd4; param_height = 12'd2; param_mode = 2'd2;
    param_color = 32'hA5A5_5A5A;
    enable = 1'b1;
    step();
    cnt = 0;
    for (int i = 0; i < 20 && m_axi4s_tvalid === 1'b1; i++) begin
      if (i == 2) param_color = 32'h1234_5678;
      if (i == 3) enable = 1'b0;
      n_checks++; if (m_axi4s_tdata !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL st_tdata beat %0d got %h want a5a55a5a", i, m_axi4s_tdata); end
      cnt++;
      step();
    end
    n_checks++; if (cnt != 8) begin n_fail++; $display("FAIL st_beats got %0d want 8", cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL st_busy got %b want 0", busy); end
    param_mode = 2'd0;
    enable = 1'b1;
    step(); step(); step();
    areset = 1'b1;
    step();
    n_checks++; if (m_axi4s_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tvalid got %b want 0", m_axi4s_tvalid); end
    n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL rst_mid_fc got %0d want 0", frame_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    areset = 1'b0;
    step();
    n_checks++; if (m_axi4s_tvalid !== 1'b1) begin n_fail++; $display("FAIL rst_re_tvalid got %b want 1", m_axi4s_tvalid); end
    n_checks++; if (m_axi4s_tuser !== 1'b1) begin n_fail++; $display("FAIL rst_re_tuser got %b want 1", m_axi4s_tuser); end
    n_checks++; if (m_axi4s_tdata !== 32'h0) begin n_fail++; $display("FAIL rst_re_tdata got %h want 0", m_axi4s_tdata); end
    enable = 1'b0;
    for (int j = 0; j < 40 && busy === 1'b1; j++) step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_re_timeout busy %b want 0", busy); end
  endtask

  task automatic test_degenerate();
    pulse_reset();
    param_width = 12'd0; param_height = 12'd0; param_mode = 2'd0;
    enable = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (m_axi4s_tvalid !== 1'b1) begin n_fail++; $display("FAIL dg_tvalid beat %0d got %b", i, m_axi4s_tvalid); end
      n_checks++; if (m_axi4s_tuser !== 1'b1) begin n_fail++; $display("FAIL dg_tuser beat %0d got %b", i, m_axi4s_tuser); end
      n_checks++; if (m_axi4s_tlast !== 1'b1) begin n_fail++; $display("FAIL dg_tlast beat %0d got %b", i, m_axi4s_tlast); end
      n_checks++; if (frame_count !== 16'(i)) begin n_fail++; $display("FAIL dg_fc beat %0d got %0d want %0d", i, frame_count, i); end
      step();
    end
    enable = 1'b0;
    step();
    n_checks++; if (frame_count !== 16'd6) begin n_fail++; $display("FAIL dg_end_fc got %0d want 6", frame_count); end
    n_checks++; if (m_axi4s_tvalid !== 1'b0) begin n_fail++; $display("FAIL dg_end_tvalid got %b want 0", m_axi4s_tvalid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dg_end_busy got %b want 0", busy); end
  endtask

  initial begin
    areset = 1'b1; enable = 1'b0; m_axi4s_tready = 1'b1;
    param_width = 12'd4; param_height = 12'd3; param_mode = 2'd0;
    param_color = 32'h0; param_hgap = 8'd0; param_vgap = 8'd0;
    test_reset();
    test_mode0();
    test_backpressure();
    test_gaps();
    test_restart_tuser();
    test_colour_bars();
    test_stop_reset();
    test_degenerate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
